// File: rtl/arbiter_game_match_ctrl_pkg.sv
// Shared types and constants for the reaction-game match sequencer.
// State encodings, LFSR seed and the LFSR step function.
package arbiter_game_match_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARM       = 3'd1,
      ST_COUNTDOWN = 3'd2,
      ST_GO        = 3'd3,
      ST_ROUND_RES = 3'd4,
      ST_MATCH_END = 3'd5
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Fibonacci form, taps 16,14,13,11 (bits 0,2,3,5 when shifting right)
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/arbiter_game_match_ctrl_game_ms_timer.sv
// Millisecond down-counter with a clk prescaler.
// done is high exactly load_val*TICK_DIV cycles after load (one cycle for load_val=0).
module game_ms_timer #(
   parameter int TICK_DIV = 12000,
   parameter int CNT_W    = 11
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   localparam int PRE_W = $clog2(TICK_DIV + 1);

   logic [PRE_W-1:0] pre_q;
   logic [CNT_W-1:0] cnt_q;
   logic             tick;

   assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst_in) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         pre_q <= '0;
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         if (tick) begin
            pre_q <= '0;
            cnt_q <= cnt_q - CNT_W'(1);
         end else begin
            pre_q <= pre_q + PRE_W'(1);
         end
      end
   end

   // terminal count seen one cycle early so the owning state lasts N*TICK_DIV cycles
   assign done = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && tick);

endmodule

// File: rtl/arbiter_game_match_ctrl.sv
// Match-level sequencer for the two-player reaction game: arms rounds, runs a random
// countdown, grants the first press after GO, scores fouls and declares the winner.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | waiting for start, nothing lit
// ST_ARM       | round armed, waiting for both buttons released
// ST_COUNTDOWN | random countdown running, any press is a foul
// ST_GO        | GO lit, first single press wins the round
// ST_ROUND_RES | round result shown for WIN_MS
// ST_MATCH_END | a player reached ROUNDS_TO_WIN, winner shown until start
module arbiter_game_match_ctrl #(
   parameter int TICK_DIV      = 12000,
   parameter int CD_MS         = 1000,
   parameter int RAND_BITS     = 10,
   parameter int WIN_MS        = 2000,
   parameter int ROUNDS_TO_WIN = 3,
   parameter int SCORE_W       = 3
) (
   input  logic               clk,
   input  logic               rst_in,
   input  logic               start,
   input  logic               req1,
   input  logic               req2,
   output logic               busy_out,
   output logic               go_led_out,
   output logic               gnt1_out,
   output logic               gnt2_out,
   output logic               foul1_out,
   output logic               foul2_out,
   output logic [SCORE_W-1:0] score1_out,
   output logic [SCORE_W-1:0] score2_out,
   output logic               match_done_out,
   output logic               match_winner_out
);

   import arbiter_game_match_ctrl_pkg::*;

   localparam int TW = $clog2(max_int(CD_MS + 2**RAND_BITS, WIN_MS) + 1);

   state_t             state_q, state_d;
   logic [15:0]        lfsr_q;
   logic [SCORE_W-1:0] score1_q, score2_q;
   logic               gnt1_q, gnt2_q, foul1_q, foul2_q;
   logic               tmr_load;
   logic [TW-1:0]      tmr_val;
   logic               tmr_done;
   logic               p1_full, p2_full;

   assign p1_full = (score1_q == SCORE_W'(ROUNDS_TO_WIN));
   assign p2_full = (score2_q == SCORE_W'(ROUNDS_TO_WIN));

   game_ms_timer #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (TW)
   ) u_timer (
      .clk      (clk),
      .rst_in   (rst_in),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   // timer is loaded on the same edge that enters the timed state
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (!req1 && !req2) begin
               state_d  = ST_COUNTDOWN;
               tmr_load = 1'b1;
               tmr_val  = TW'(CD_MS) + TW'(lfsr_q[RAND_BITS-1:0]);
            end
         end
         ST_COUNTDOWN: begin
            if (req1 || req2) begin
               state_d  = ST_ROUND_RES;
               tmr_load = 1'b1;
               tmr_val  = TW'(WIN_MS);
            end else if (tmr_done) begin
               state_d = ST_GO;
            end
         end
         ST_GO: begin
            if (req1 ^ req2) begin
               state_d  = ST_ROUND_RES;
               tmr_load = 1'b1;
               tmr_val  = TW'(WIN_MS);
            end
         end
         ST_ROUND_RES: begin
            if (tmr_done) state_d = (p1_full || p2_full) ? ST_MATCH_END : ST_ARM;
         end
         ST_MATCH_END: begin
            if (start) state_d = ST_ARM;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         score1_q <= '0;
         score2_q <= '0;
         gnt1_q   <= 1'b0;
         gnt2_q   <= 1'b0;
         foul1_q  <= 1'b0;
         foul2_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_MATCH_END: begin
               if (start) begin
                  score1_q <= '0;
                  score2_q <= '0;
               end
            end
            ST_COUNTDOWN: begin
               if (req1 && req2) begin
                  foul1_q <= 1'b1;
                  foul2_q <= 1'b1;
               end else if (req1) begin
                  foul1_q <= 1'b1;
                  if (!p2_full) score2_q <= score2_q + SCORE_W'(1);
               end else if (req2) begin
                  foul2_q <= 1'b1;
                  if (!p1_full) score1_q <= score1_q + SCORE_W'(1);
               end
            end
            ST_GO: begin
               if (req1 && !req2) begin
                  gnt1_q <= 1'b1;
                  if (!p1_full) score1_q <= score1_q + SCORE_W'(1);
               end else if (req2 && !req1) begin
                  gnt2_q <= 1'b1;
                  if (!p2_full) score2_q <= score2_q + SCORE_W'(1);
               end
            end
            ST_ROUND_RES: begin
               if (tmr_done) begin
                  gnt1_q  <= 1'b0;
                  gnt2_q  <= 1'b0;
                  foul1_q <= 1'b0;
                  foul2_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy_out         = (state_q != ST_IDLE) && (state_q != ST_MATCH_END);
      go_led_out       = (state_q == ST_GO);
      gnt1_out         = gnt1_q;
      gnt2_out         = gnt2_q;
      foul1_out        = foul1_q;
      foul2_out        = foul2_q;
      score1_out       = score1_q;
      score2_out       = score2_q;
      match_done_out   = (state_q == ST_MATCH_END);
      match_winner_out = (state_q == ST_MATCH_END) && p2_full;
   end

endmodule
